branch_resolve: RTL and testbench
=================================

BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 The module SHALL have parameter DWIDTH, default 32, meaning operand and immediate width.
REQ-002 The module SHALL have parameter AWIDTH, default 32, meaning PC width.
REQ-003 The module SHALL have parameter BASEADDR, default 32'h01000000, meaning the PC value after reset.
REQ-004 The module SHALL have parameter FLUSH_CYCLES, default 2, legal range 1-7, meaning the number of cycles flush_o is held after a redirect.
REQ-005 Ports SHALL be, clock and reset first: clk input 1 (rising-edge clock); reset input 1 (synchronous, active-high reset).
REQ-006 valid_i input 1: execute-stage instruction valid; opcode_i input 7; funct3_i input 3.
REQ-007 breq_i input 1 and brlt_i input 1: comparator results for rs1 versus rs2, with signedness selected upstream by funct3.
REQ-008 pc_i input AWIDTH: PC of the execute-stage instruction; imm_i input DWIDTH: sign-extended immediate; rs1_i input DWIDTH: rs1 data, used by JALR.
REQ-009 stall_i input 1: freeze the PC and FSM.
REQ-010 pc_o output AWIDTH: fetch PC register; redirect_o output 1: one-cycle redirect pulse; flush_o output 1: squash the younger pipeline stages; taken_o output 1: registered resolution of the last accepted control instruction.

Function
REQ-011 An instruction SHALL be accepted on a rising edge where valid_i=1, stall_i=0 and state=RUN.
REQ-012 Taken SHALL be decided as follows when opcode_i=BRANCH (1100011):
- BEQ: taken = breq.
- BNE: taken = !breq.
- BLT and BLTU: taken = brlt.
- BGE and BGEU: taken = !brlt.
- funct3 010 or 011: not taken.
REQ-013 JAL (1101111) and JALR (1100111) SHALL always be taken; every other opcode SHALL be not taken.
REQ-014 The target for a branch or JAL SHALL be pc_i+imm_i; the target for JALR SHALL be (rs1_i+imm_i) with bit 0 cleared; all sums SHALL be modulo 2^AWIDTH.
REQ-015 The FSM SHALL have two states, RUN and FLUSH.
REQ-016 In RUN, on a taken accept, the module SHALL, at that edge:
- load pc_o with the target;
- assert redirect_o for exactly the following cycle;
- load the flush counter with FLUSH_CYCLES;
- enter FLUSH.
REQ-017 In RUN, on a not-taken accept or when valid_i=0, and with stall_i=0, pc_o SHALL increment by 4 with wrap-around at 2^AWIDTH.
REQ-018 taken_o SHALL update only on an accept and SHALL hold otherwise.
REQ-019 In FLUSH, flush_o SHALL be 1, valid_i SHALL be ignored, pc_o SHALL increment by 4 per unstalled cycle, and the counter SHALL decrement per unstalled cycle; the FSM SHALL return to RUN when the counter reaches 0.
REQ-020 While stall_i=1, pc_o, the state, the counter and taken_o SHALL all hold; redirect_o SHALL still drop after one cycle.
REQ-021 stall_i and valid_i asserted together SHALL defer resolution until stall_i falls; the inputs are required to be held stable meanwhile.
REQ-022 Latency SHALL be one cycle from accept to pc_o and redirect_o updating.

Reset
REQ-023 While reset=1 at a clock edge: pc_o=BASEADDR, redirect_o=0, flush_o=0, taken_o=0, state=RUN, counter=0, and any statistics counters=0.
REQ-024 Reset mid-FLUSH SHALL abort the flush immediately; reset SHALL take priority over stall_i and valid_i.

Configuration
REQ-025 With macro BRANCH_STATS_EN defined, the module SHALL add two outputs, both 32 bits and saturating at 32'hFFFFFFFF:
- branch_cnt_o: count of accepted BRANCH-opcode instructions;
- taken_cnt_o: count of accepted taken BRANCH-opcode instructions.
REQ-026 Without BRANCH_STATS_EN, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-027 Reset then 3 unstalled cycles with valid_i=0 -> pc_o sequence 0x01000000, 0x01000004, 0x01000008, 0x0100000C; flush_o=0.
REQ-028 BEQ with breq=1, pc_i=0x01000010, imm=0x20 -> next cycle pc_o=0x01000030, redirect_o=1 for 1 cycle, flush_o=1 for 2 cycles, taken_o=1.
REQ-029 BNE with breq=1, and BGEU with brlt=1 -> no redirect, pc_o+4, taken_o=0; funct3=010 -> not taken.
REQ-030 JALR with rs1=0x01000101, imm=0x4 -> pc_o=0x01000104; JAL with pc_i=0x01000000, imm=-8 -> pc_o=0x00FFFFF8.
REQ-031 Taken branch, then stall_i=1 for 3 cycles during FLUSH -> flush_o lasts 5 cycles, pc_o frozen during the stall; a valid_i pulse during FLUSH is ignored.
REQ-032 Reset asserted during FLUSH -> next cycle pc_o=0x01000000, flush_o=0; with BRANCH_STATS_EN, 4 branches of which 3 are taken -> branch_cnt_o=4, taken_cnt_o=3.

Source files
------------

// File: rtl/branch_resolve_if.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_if
// Description : Execute-stage control-transfer bus between the pipeline and
//               the branch resolution unit. The optional statistics outputs
//               exist only when BRANCH_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface branch_resolve_if #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32
);
    logic              valid_i;
    logic [6:0]        opcode_i;
    logic [2:0]        funct3_i;
    logic              breq_i;
    logic              brlt_i;
    logic [AWIDTH-1:0] pc_i;
    logic [DWIDTH-1:0] imm_i;
    logic [DWIDTH-1:0] rs1_i;
    logic              stall_i;
    logic [AWIDTH-1:0] pc_o;
    logic              redirect_o;
    logic              flush_o;
    logic              taken_o;
`ifdef BRANCH_STATS_EN
    logic [31:0]       branch_cnt_o;
    logic [31:0]       taken_cnt_o;

    modport master (
        output valid_i, opcode_i, funct3_i, breq_i, brlt_i, pc_i, imm_i, rs1_i, stall_i,
        input  pc_o, redirect_o, flush_o, taken_o, branch_cnt_o, taken_cnt_o
    );
    modport slave (
        input  valid_i, opcode_i, funct3_i, breq_i, brlt_i, pc_i, imm_i, rs1_i, stall_i,
        output pc_o, redirect_o, flush_o, taken_o, branch_cnt_o, taken_cnt_o
    );
`else
    modport master (
        output valid_i, opcode_i, funct3_i, breq_i, brlt_i, pc_i, imm_i, rs1_i, stall_i,
        input  pc_o, redirect_o, flush_o, taken_o
    );
    modport slave (
        input  valid_i, opcode_i, funct3_i, breq_i, brlt_i, pc_i, imm_i, rs1_i, stall_i,
        output pc_o, redirect_o, flush_o, taken_o
    );
`endif
endinterface
`default_nettype wire

// File: rtl/branch_resolve.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve
// Description : Resolves execute-stage branches/jumps, owns the fetch PC and
//               squashes younger stages for FLUSH_CYCLES after a redirect.
//               Define BRANCH_STATS_EN to add saturating branch counters.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve #(
    parameter int                DWIDTH       = 32,
    parameter int                AWIDTH       = 32,
    parameter logic [AWIDTH-1:0] BASEADDR     = AWIDTH'(32'h01000000),
    parameter int                FLUSH_CYCLES = 2
) (
    input  wire               clk,
    input  wire               reset,
    branch_resolve_if.slave   bus
);
    localparam logic [6:0] c_op_branch  = 7'b1100011;
    localparam logic [6:0] c_op_jal     = 7'b1101111;
    localparam logic [6:0] c_op_jalr    = 7'b1100111;
    localparam logic [0:0] c_run        = 1'b0;
    localparam logic [0:0] c_flush      = 1'b1;
    localparam logic [2:0] c_flush_load = 3'(FLUSH_CYCLES);

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [2:0]        r_cnt;
    logic [2:0]        w_cnt_nxt;
    logic [AWIDTH-1:0] r_pc;
    logic              r_redirect;
    logic              r_taken;
    logic              w_flush;
    logic              w_taken;
    logic              w_accept;
    logic              w_redirect_now;
    logic [AWIDTH-1:0] w_imm_a;
    logic [AWIDTH-1:0] w_rs1_a;
    logic [AWIDTH-1:0] w_jalr_sum;
    logic [AWIDTH-1:0] w_target;

    // Bring the operand-width immediate and rs1 onto the PC width
    generate
        if (DWIDTH >= AWIDTH) begin : g_addr_trunc
            assign w_imm_a = bus.imm_i[AWIDTH-1:0];
            assign w_rs1_a = bus.rs1_i[AWIDTH-1:0];
        end else begin : g_addr_sext
            assign w_imm_a = {{(AWIDTH-DWIDTH){bus.imm_i[DWIDTH-1]}}, bus.imm_i};
            assign w_rs1_a = {{(AWIDTH-DWIDTH){1'b0}}, bus.rs1_i};
        end
    endgenerate

    assign w_jalr_sum     = w_rs1_a + w_imm_a;
    assign w_target       = (bus.opcode_i == c_op_jalr)
                          ? (w_jalr_sum & {{(AWIDTH-1){1'b1}}, 1'b0})
                          : (bus.pc_i + w_imm_a);
    assign w_accept       = bus.valid_i & ~bus.stall_i & (r_state == c_run);
    assign w_redirect_now = w_accept & w_taken;

    // Taken decision from opcode, funct3 and the upstream comparator flags
    always_comb begin
        w_taken = 1'b0;
        case (bus.opcode_i)
            c_op_branch: begin
                case (bus.funct3_i)
                    3'b000:         w_taken = bus.breq_i;
                    3'b001:         w_taken = ~bus.breq_i;
                    3'b100, 3'b110: w_taken = bus.brlt_i;
                    3'b101, 3'b111: w_taken = ~bus.brlt_i;
                    default:        w_taken = 1'b0;
                endcase
            end
            c_op_jal, c_op_jalr: w_taken = 1'b1;
            default:             w_taken = 1'b0;
        endcase
    end

    // FSM state and flush counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_run;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state: a taken accept opens a flush window; each unstalled cycle consumes one slot
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (!bus.stall_i) begin
            case (r_state)
                c_run: begin
                    if (w_redirect_now) begin
                        w_state_nxt = c_flush;
                        w_cnt_nxt   = c_flush_load;
                    end
                end
                c_flush: begin
                    w_cnt_nxt = r_cnt - 3'd1;
                    if (r_cnt <= 3'd1) begin
                        w_state_nxt = c_run;
                        w_cnt_nxt   = 3'd0;
                    end
                end
                default: begin
                    w_state_nxt = c_run;
                    w_cnt_nxt   = 3'd0;
                end
            endcase
        end
    end

    // Moore output: squash younger stages for the whole flush window
    always_comb begin
        w_flush = 1'b0;
        if (r_state == c_flush) begin
            w_flush = 1'b1;
        end
    end

    // Fetch PC, one-cycle redirect pulse and last resolution
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= BASEADDR;
            r_redirect <= 1'b0;
            r_taken    <= 1'b0;
        end else begin
            r_redirect <= w_redirect_now;
            if (!bus.stall_i) begin
                r_pc <= w_redirect_now ? w_target : (r_pc + AWIDTH'(4));
            end
            if (w_accept) begin
                r_taken <= w_taken;
            end
        end
    end

    assign bus.pc_o       = r_pc;
    assign bus.redirect_o = r_redirect;
    assign bus.flush_o    = w_flush;
    assign bus.taken_o    = r_taken;

`ifdef BRANCH_STATS_EN
    logic [31:0] r_branch_cnt;
    logic [31:0] r_taken_cnt;
    logic        w_branch_acc;

    assign w_branch_acc = w_accept & (bus.opcode_i == c_op_branch);

    // Saturating counts of accepted conditional branches and of those taken
    always_ff @(posedge clk) begin
        if (reset) begin
            r_branch_cnt <= 32'd0;
            r_taken_cnt  <= 32'd0;
        end else begin
            if (w_branch_acc && (r_branch_cnt != 32'hFFFFFFFF)) begin
                r_branch_cnt <= r_branch_cnt + 32'd1;
            end
            if (w_branch_acc && w_taken && (r_taken_cnt != 32'hFFFFFFFF)) begin
                r_taken_cnt <= r_taken_cnt + 32'd1;
            end
        end
    end

    assign bus.branch_cnt_o = r_branch_cnt;
    assign bus.taken_cnt_o  = r_taken_cnt;
`endif
endmodule
`default_nettype wire

// File: tb/tb_branch_resolve.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_resolve
// Description : Self-checking bench for branch_resolve: directed scenarios
//               plus randomized traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve;
    localparam int          DW   = 32;
    localparam int          AW   = 32;
    localparam int          FC   = 2;
    localparam logic [31:0] BASE = 32'h01000000;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_JALR   = 7'b1100111;
    localparam logic [6:0]  OP_ALU    = 7'b0110011;
    localparam logic [6:0]  OP_ALUI   = 7'b0010011;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    branch_resolve_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

    branch_resolve #(
        .DWIDTH(DW), .AWIDTH(AW), .BASEADDR(BASE), .FLUSH_CYCLES(FC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state
    logic [31:0] m_pc;
    int          m_flush_left;
    logic        m_redirect;
    logic        m_taken;
    logic [31:0] m_bcnt;
    logic [31:0] m_tcnt;

    function automatic logic ref_taken(input logic [6:0] op, input logic [2:0] f3,
                                       input logic eq, input logic lt);
        if (op == OP_BRANCH) begin
            case (f3)
                3'd0:       return eq;
                3'd1:       return !eq;
                3'd4, 3'd6: return lt;
                3'd5, 3'd7: return !lt;
                default:    return 1'b0;
            endcase
        end
        return (op == OP_JAL) || (op == OP_JALR);
    endfunction

    function automatic logic [31:0] ref_target(input logic [6:0] op, input logic [31:0] pc,
                                               input logic [31:0] imm, input logic [31:0] rs1);
        logic [31:0] s;
        if (op == OP_JALR) begin
            s = rs1 + imm;
            return {s[31:1], 1'b0};
        end
        return pc + imm;
    endfunction

    task automatic model_step();
        logic acc;
        logic tk;
        if (reset) begin
            m_pc = BASE; m_flush_left = 0; m_redirect = 1'b0; m_taken = 1'b0;
            m_bcnt = 32'd0; m_tcnt = 32'd0;
            return;
        end
        acc = bus.valid_i && !bus.stall_i && (m_flush_left == 0);
        tk  = ref_taken(bus.opcode_i, bus.funct3_i, bus.breq_i, bus.brlt_i);
        m_redirect = acc && tk;
        if (acc) begin
            m_taken = tk;
            if (bus.opcode_i == OP_BRANCH) begin
                if (m_bcnt != 32'hFFFFFFFF) m_bcnt = m_bcnt + 1;
                if (tk && m_tcnt != 32'hFFFFFFFF) m_tcnt = m_tcnt + 1;
            end
        end
        if (!bus.stall_i) begin
            if (m_flush_left > 0) begin
                m_pc = m_pc + 4;
                m_flush_left = m_flush_left - 1;
            end else if (acc && tk) begin
                m_pc = ref_target(bus.opcode_i, bus.pc_i, bus.imm_i, bus.rs1_i);
                m_flush_left = FC;
            end else begin
                m_pc = m_pc + 4;
            end
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                         input logic eq, input logic lt, input logic [31:0] pc,
                         input logic [31:0] imm, input logic [31:0] rs1);
        bus.valid_i = v;   bus.opcode_i = op; bus.funct3_i = f3;
        bus.breq_i  = eq;  bus.brlt_i   = lt; bus.pc_i     = pc;
        bus.imm_i   = imm; bus.rs1_i    = rs1;
    endtask

    task automatic idle();
        drive(1'b0, OP_ALU, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.stall_i = 1'b0; idle();
        tick(); tick();
        n_checks++; if (bus.pc_o !== BASE) $display("FAIL reset_pc: got %h want %h", bus.pc_o, BASE); else n_pass++;
        n_checks++; if (bus.redirect_o !== 1'b0) $display("FAIL reset_redirect: got %b want 0", bus.redirect_o); else n_pass++;
        n_checks++; if (bus.flush_o !== 1'b0) $display("FAIL reset_flush: got %b want 0", bus.flush_o); else n_pass++;
        n_checks++; if (bus.taken_o !== 1'b0) $display("FAIL reset_taken: got %b want 0", bus.taken_o); else n_pass++;
`ifdef BRANCH_STATS_EN
        n_checks++; if (bus.branch_cnt_o !== 32'd0) $display("FAIL reset_bcnt: got %0d want 0", bus.branch_cnt_o); else n_pass++;
        n_checks++; if (bus.taken_cnt_o !== 32'd0) $display("FAIL reset_tcnt: got %0d want 0", bus.taken_cnt_o); else n_pass++;
`endif
    endtask

    task automatic test_sequential();
        reset = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_checks++; if (bus.pc_o !== BASE + 32'(4 * i)) $display("FAIL seq_pc%0d: got %h want %h", i, bus.pc_o, BASE + 32'(4 * i)); else n_pass++;
            n_checks++; if (bus.flush_o !== 1'b0) $display("FAIL seq_flush%0d: got %b want 0", i, bus.flush_o); else n_pass++;
        end
    endtask

    task automatic test_beq();
        drive(1'b1, OP_BRANCH, 3'd0, 1'b1, 1'b0, 32'h01000010, 32'h20, 32'd0);
        tick();
        n_checks++; if (bus.pc_o !== 32'h01000030) $display("FAIL beq_pc: got %h want %h", bus.pc_o, 32'h01000030); else n_pass++;
        n_checks++; if (bus.redirect_o !== 1'b1) $display("FAIL beq_redirect: got %b want 1", bus.redirect_o); else n_pass++;
        n_checks++; if (bus.flush_o !== 1'b1) $display("FAIL beq_flush1: got %b want 1", bus.flush_o); else n_pass++;
        n_checks++; if (bus.taken_o !== 1'b1) $display("FAIL beq_taken: got %b want 1", bus.taken_o); else n_pass++;
        idle();
        tick();
        n_checks++; if (bus.redirect_o !== 1'b0) $display("FAIL beq_redirect_drop: got %b want 0", bus.redirect_o); else n_pass++;
        n_checks++; if (bus.flush_o !== 1'b1) $display("FAIL beq_flush2: got %b want 1", bus.flush_o); else n_pass++;
        n_checks++; if (bus.pc_o !== 32'h01000034) $display("FAIL beq_pc2: got %h want %h", bus.pc_o, 32'h01000034); else n_pass++;
        tick();
        n_checks++; if (bus.flush_o !== 1'b0) $display("FAIL beq_flush_end: got %b want 0", bus.flush_o); else n_pass++;
        n_checks++; if (bus.pc_o !== 32'h01000038) $display("FAIL beq_pc3: got %h want %h", bus.pc_o, 32'h01000038); else n_pass++;
        n_checks++; if (bus.taken_o !== 1'b1) $display("FAIL beq_taken_hold: got %b want 1", bus.taken_o); else n_pass++;
    endtask

    task automatic test_not_taken();
        drive(1'b1, OP_BRANCH, 3'd1, 1'b1, 1'b0, 32'h01000038, 32'h100, 32'd0);
        tick();
        n_checks++; if (bus.pc_o !== 32'h0100003C) $display("FAIL bne_pc: got %h want %h", bus.pc_o, 32'h0100003C); else n_pass++;
        n_checks++; if (bus.redirect_o !== 1'b0) $display("FAIL bne_redirect: got %b want 0", bus.redirect_o); else n_pass++;
        n_checks++; if (bus.taken_o !== 1'b0) $display("FAIL bne_taken: got %b want 0", bus.taken_o); else n_pass++;
        drive(1'b1, OP_BRANCH, 3'd7, 1'b0, 1'b1, 32'h0100003C, 32'h100, 32'd0);
        tick();
        n_checks++; if (bus.pc_o !== 32'h01000040) $display("FAIL bgeu_pc: got %h want %h", bus.pc_o, 32'h01000040); else n_pass++;
        n_checks++; if (bus.redirect_o !== 1'b0) $display("FAIL bgeu_redirect: got %b want 0", bus.redirect_o); else n_pass++;
        drive(1'b1, OP_BRANCH, 3'd2, 1'b1, 1'b1, 32'h01000040, 32'h100, 32'd0);
        tick();
        n_checks++; if (bus.pc_o !== 32'h01000044) $display("FAIL f3_010_pc: got %h want %h", bus.pc_o, 32'h01000044); else n_pass++;
        n_checks++; if (bus.flush_o !== 1'b0) $display("FAIL f3_010_flush: got %b want 0", bus.flush_o); else n_pass++;
        drive(1'b1, OP_ALUI, 3'd0, 1'b1, 1'b1, 32'h01000044, 32'h100, 32'd0);
        tick();
        n_checks++; if (bus.pc_o !== 32'h01000048) $display("FAIL alu_pc: got %h want %h", bus.pc_o, 32'h01000048); else n_pass++;
        n_checks++; if (bus.taken_o !== 1'b0) $display("FAIL alu_taken: got %b want 0", bus.taken_o); else n_pass++;
        idle();
    endtask

    task automatic test_jumps();
        drive(1'b1, OP_JALR, 3'd0, 1'b0, 1'b0, 32'h01000048, 32'h4, 32'h01000101);
        tick();
        n_checks++; if (bus.pc_o !== 32'h01000104) $display("FAIL jalr_pc: got %h want %h", bus.pc_o, 32'h01000104); else n_pass++;
        n_checks++; if (bus.redirect_o !== 1'b1) $display("FAIL jalr_redirect: got %b want 1", bus.redirect_o); else n_pass++;
        idle(); tick(); tick();
        n_checks++; if (bus.pc_o !== 32'h0100010C) $display("FAIL jalr_after: got %h want %h", bus.pc_o, 32'h0100010C); else n_pass++;
        drive(1'b1, OP_JAL, 3'd0, 1'b0, 1'b0, 32'h01000000, 32'hFFFFFFF8, 32'd0);
        tick();
        n_checks++; if (bus.pc_o !== 32'h00FFFFF8) $display("FAIL jal_neg_pc: got %h want %h", bus.pc_o, 32'h00FFFFF8); else n_pass++;
        n_checks++; if (bus.taken_o !== 1'b1) $display("FAIL jal_taken: got %b want 1", bus.taken_o); else n_pass++;
        idle(); tick(); tick();
        drive(1'b1, OP_JAL, 3'd0, 1'b0, 1'b0, 32'hFFFFFFF0, 32'h8, 32'd0);
        tick();
        n_checks++; if (bus.pc_o !== 32'hFFFFFFF8) $display("FAIL jal_top_pc: got %h want %h", bus.pc_o, 32'hFFFFFFF8); else n_pass++;
        idle(); tick(); tick();
        n_checks++; if (bus.pc_o !== 32'h00000000) $display("FAIL pc_wrap: got %h want %h", bus.pc_o, 32'h00000000); else n_pass++;
        n_checks++; if (bus.flush_o !== 1'b0) $display("FAIL wrap_flush: got %b want 0", bus.flush_o); else n_pass++;
    endtask

    task automatic test_stall_flush();
        int n_flush;
        n_flush = 0;
        drive(1'b1, OP_BRANCH, 3'd4, 1'b0, 1'b1, 32'h00000100, 32'h100, 32'd0);
        tick();
        if (bus.flush_o === 1'b1) n_flush++;
        n_checks++; if (bus.pc_o !== 32'h00000200) $display("FAIL blt_pc: got %h want %h", bus.pc_o, 32'h00000200); else n_pass++;
        idle();
        bus.stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.flush_o === 1'b1) n_flush++;
            n_checks++; if (bus.pc_o !== 32'h00000200) $display("FAIL stall_pc%0d: got %h want %h", i, bus.pc_o, 32'h00000200); else n_pass++;
            n_checks++; if (bus.redirect_o !== 1'b0) $display("FAIL stall_redirect%0d: got %b want 0", i, bus.redirect_o); else n_pass++;
        end
        bus.stall_i = 1'b0;
        drive(1'b1, OP_JAL, 3'd0, 1'b0, 1'b0, 32'h00000000, 32'h40, 32'd0);
        tick();
        if (bus.flush_o === 1'b1) n_flush++;
        n_checks++; if (bus.pc_o !== 32'h00000204) $display("FAIL flush_ignore_pc: got %h want %h", bus.pc_o, 32'h00000204); else n_pass++;
        n_checks++; if (bus.redirect_o !== 1'b0) $display("FAIL flush_ignore_redirect: got %b want 0", bus.redirect_o); else n_pass++;
        idle();
        tick();
        if (bus.flush_o === 1'b1) n_flush++;
        n_checks++; if (bus.pc_o !== 32'h00000208) $display("FAIL flush_exit_pc: got %h want %h", bus.pc_o, 32'h00000208); else n_pass++;
        n_checks++; if (n_flush != 5) $display("FAIL flush_len: got %0d want 5", n_flush); else n_pass++;
    endtask

    task automatic test_reset_mid_flush();
        drive(1'b1, OP_BRANCH, 3'd0, 1'b1, 1'b0, 32'h01000000, 32'h80, 32'd0);
        tick();
        n_checks++; if (bus.flush_o !== 1'b1) $display("FAIL rmf_flush_on: got %b want 1", bus.flush_o); else n_pass++;
        reset = 1'b1;
        bus.stall_i = 1'b1;
        tick();
        n_checks++; if (bus.pc_o !== BASE) $display("FAIL rmf_pc: got %h want %h", bus.pc_o, BASE); else n_pass++;
        n_checks++; if (bus.flush_o !== 1'b0) $display("FAIL rmf_flush: got %b want 0", bus.flush_o); else n_pass++;
        n_checks++; if (bus.taken_o !== 1'b0) $display("FAIL rmf_taken: got %b want 0", bus.taken_o); else n_pass++;
        reset = 1'b0;
        bus.stall_i = 1'b0;
        idle();
        tick();
        n_checks++; if (bus.pc_o !== BASE + 32'd4) $display("FAIL rmf_resume: got %h want %h", bus.pc_o, BASE + 32'd4); else n_pass++;
    endtask

`ifdef BRANCH_STATS_EN
    task automatic test_stats();
        reset = 1'b1; idle(); tick(); reset = 1'b0;
        drive(1'b1, OP_BRANCH, 3'd0, 1'b1, 1'b0, 32'h100, 32'h10, 32'd0); tick(); idle(); tick(); tick();
        drive(1'b1, OP_BRANCH, 3'd1, 1'b1, 1'b0, 32'h100, 32'h10, 32'd0); tick();
        drive(1'b1, OP_BRANCH, 3'd4, 1'b0, 1'b1, 32'h100, 32'h10, 32'd0); tick(); idle(); tick(); tick();
        drive(1'b1, OP_BRANCH, 3'd5, 1'b0, 1'b0, 32'h100, 32'h10, 32'd0); tick(); idle(); tick(); tick();
        drive(1'b1, OP_JAL, 3'd0, 1'b0, 1'b0, 32'h100, 32'h10, 32'd0); tick(); idle(); tick(); tick();
        n_checks++; if (bus.branch_cnt_o !== 32'd4) $display("FAIL stats_bcnt: got %0d want 4", bus.branch_cnt_o); else n_pass++;
        n_checks++; if (bus.taken_cnt_o !== 32'd3) $display("FAIL stats_tcnt: got %0d want 3", bus.taken_cnt_o); else n_pass++;
    endtask
`endif

    task automatic test_random();
        logic [6:0] ops [5];
        ops[0] = OP_BRANCH; ops[1] = OP_BRANCH; ops[2] = OP_JAL; ops[3] = OP_JALR; ops[4] = OP_ALU;
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), ops[$urandom_range(0, 4)], 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom(),
                  ($urandom_range(0, 1) == 0) ? 32'($signed(12'($urandom()))) : $urandom(), $urandom());
            bus.stall_i = ($urandom_range(0, 3) == 0);
            tick();
            n_checks++; if (bus.pc_o !== m_pc) $display("FAIL rand_pc@%0d: got %h want %h", i, bus.pc_o, m_pc); else n_pass++;
            n_checks++; if (bus.redirect_o !== m_redirect) $display("FAIL rand_redirect@%0d: got %b want %b", i, bus.redirect_o, m_redirect); else n_pass++;
            n_checks++; if (bus.flush_o !== (m_flush_left > 0)) $display("FAIL rand_flush@%0d: got %b want %b", i, bus.flush_o, (m_flush_left > 0)); else n_pass++;
            n_checks++; if (bus.taken_o !== m_taken) $display("FAIL rand_taken@%0d: got %b want %b", i, bus.taken_o, m_taken); else n_pass++;
`ifdef BRANCH_STATS_EN
            n_checks++; if (bus.branch_cnt_o !== m_bcnt) $display("FAIL rand_bcnt@%0d: got %0d want %0d", i, bus.branch_cnt_o, m_bcnt); else n_pass++;
            n_checks++; if (bus.taken_cnt_o !== m_tcnt) $display("FAIL rand_tcnt@%0d: got %0d want %0d", i, bus.taken_cnt_o, m_tcnt); else n_pass++;
`endif
        end
        bus.stall_i = 1'b0;
        idle();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_beq();
        test_not_taken();
        test_jumps();
        test_stall_flush();
        test_reset_mid_flush();
`ifdef BRANCH_STATS_EN
        test_stats();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
